// File: rtl/aes_state_fifo_if.sv
// Handshake bundle for the AES state buffer: push side (source states + round tag)
// and pop side (head state + round tag).
interface aes_state_fifo_if #(
  parameter int NBYTES  = 16,
  parameter int NSRC    = 2,
  parameter int ROUND_W = 4
);
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic                             in_valid;
  logic                             in_ready;
  logic [ROUND_W-1:0]               round;
  logic [SEL_W-1:0]                 src_sel;
  logic [NSRC-1:0][NBYTES-1:0][7:0] src_state;
  logic                             o_valid;
  logic                             o_ready;
  logic [NBYTES-1:0][7:0]           o_state;
  logic [ROUND_W-1:0]               o_round;

  modport master (
    output in_valid, round, src_sel, src_state, o_ready,
    input  in_ready, o_valid, o_state, o_round
  );

  modport slave (
    input  in_valid, round, src_sel, src_state, o_ready,
    output in_ready, o_valid, o_state, o_round
  );
endinterface

// File: rtl/aes_state_fifo.sv
// AES state buffer: captures one state per push from a selected source channel and
// holds up to DEPTH states with their round tags, first-word fall-through on output.
module aes_state_fifo #(
  parameter int NBYTES     = 16,
  parameter int NSRC       = 2,
  parameter int DEPTH      = 2,
  parameter int ROUND_W    = 4,
  parameter int LAST_ROUND = 14,
  parameter int AUTO_SEL   = 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  aes_state_fifo_if.slave  bus,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = 8 * NBYTES;
  localparam int EW    = SW + ROUND_W;

  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [ROUND_W-1:0] FINAL_RND = ROUND_W'(LAST_ROUND);

  logic [EW-1:0]      mem_q [DEPTH];
  logic [EW-1:0]      mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SEL_W-1:0]   expl_idx, src_idx;
  logic [SW-1:0]      sel_state;
  logic               push, pop;

  // Final round skips MixColumns, so its state comes from channel 1 in auto mode.
  always_comb begin
    expl_idx = '0;
    if (int'(bus.src_sel) < NSRC) expl_idx = bus.src_sel;
    src_idx = expl_idx;
    if (AUTO_SEL != 0) src_idx = (bus.round == FINAL_RND) ? SEL_W'(1) : '0;
    sel_state = bus.src_state[src_idx];
  end

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on the registered count, so a pop never frees a same-cycle push.
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign bus.in_ready = !full;
  assign bus.o_valid  = !empty;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = bus.o_valid & bus.o_ready;

  always_comb begin
    bus.o_state = '0;
    bus.o_round = '0;
    if (!empty) {bus.o_round, bus.o_state} = mem_q[rd_ptr_q];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {bus.round, sel_state};
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule
